// File: rtl/wb_copy_master.sv
// wb_copy_master
// Wishbone initiator that copies a block of bytes from a source address range
// to a destination address range over one shared bus. Each access is a single
// one-cycle strobe, followed by a wait for the responder's acknowledge.
//
// Optional feature macro: WB_COPY_FILL_EN
//   When defined, fill_i / fill_dat_i are added. A start with fill_i=1 skips
//   every read and writes fill_dat_i to each destination byte.
//
// Handshake: stb_o is high for exactly one cycle per access and is low for at
// least one cycle between accesses. The responder answers with ack_i in a
// later cycle. ack_i is only honoured in RD_WAIT / WR_WAIT. If a wait state
// sees no ack_i for TIMEOUT cycles, the copy aborts with err_o set. An ack_i
// in the cycle the limit is reached still counts as a normal acknowledge.
module wb_copy_master #(
  parameter int WB_DATA_WIDTH = 8,
  parameter int WB_ADDR_WIDTH = 9,
  parameter int LEN_WIDTH     = 10,
  parameter int TIMEOUT       = 15
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [WB_ADDR_WIDTH-1:0] src_i,
  input  logic [WB_ADDR_WIDTH-1:0] dst_i,
  input  logic [LEN_WIDTH-1:0]     len_i,
`ifdef WB_COPY_FILL_EN
  input  logic                     fill_i,
  input  logic [WB_DATA_WIDTH-1:0] fill_dat_i,
`endif
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic                     stb_o,
  output logic                     we_o,
  output logic [WB_ADDR_WIDTH-1:0] adr_o,
  output logic [WB_DATA_WIDTH-1:0] dat_o,
  input  logic                     ack_i,
  input  logic [WB_DATA_WIDTH-1:0] dat_i,
  output logic [2:0]               dbg_state_o
);

  // FSM encoding
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_WAIT = 3'd4;

  // The wait counter only has to reach TIMEOUT-1: the abort happens on the
  // TIMEOUT-th cycle without an acknowledge.
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  logic [2:0]               state_q, state_d;
  logic [WB_ADDR_WIDTH-1:0] src_q, src_d;
  logic [WB_ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_WIDTH-1:0]     rem_q, rem_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;
  logic                     stb_q, stb_d;
  logic                     we_q, we_d;
  logic [WB_ADDR_WIDTH-1:0] adr_q, adr_d;
  // dat_q doubles as the holding register between the read and the write.
  logic [WB_DATA_WIDTH-1:0] dat_q, dat_d;

  // Fill-mode control. Tied off when the feature is not built in.
  logic                     fill_mode;
  logic                     fill_req;
  logic [WB_DATA_WIDTH-1:0] fill_dat;

`ifdef WB_COPY_FILL_EN
  logic fill_q;

  // Remember whether the current transfer is a fill, sampled with start
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fill_q <= 1'b0;
    end else if (state_q == S_IDLE && start_i) begin
      fill_q <= fill_i;
    end
  end

  assign fill_mode = fill_q;
  assign fill_req  = fill_i;
  assign fill_dat  = fill_dat_i;
`else
  assign fill_mode = 1'b0;
  assign fill_req  = 1'b0;
  assign fill_dat  = '0;
`endif

  // Next-state and next-output logic for the copy sequencer
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    tmo_d   = tmo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    stb_d   = 1'b0;
    we_d    = 1'b0;
    adr_d   = adr_q;
    dat_d   = dat_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          src_d = src_i;
          dst_d = dst_i;
          rem_d = len_i;
          err_d = 1'b0;
          if (len_i == '0) begin
            // Empty copy: report completion without touching the bus
            done_d = 1'b1;
          end else begin
            busy_d = 1'b1;
            stb_d  = 1'b1;
            if (fill_req) begin
              state_d = S_WR_REQ;
              we_d    = 1'b1;
              adr_d   = dst_i;
              dat_d   = fill_dat;
            end else begin
              state_d = S_RD_REQ;
              adr_d   = src_i;
            end
          end
        end
      end

      S_RD_REQ: begin
        state_d = S_RD_WAIT;
        tmo_d   = '0;
      end

      S_RD_WAIT: begin
        if (ack_i) begin
          dat_d   = dat_i;
          src_d   = src_q + 1'b1;
          state_d = S_WR_REQ;
          stb_d   = 1'b1;
          we_d    = 1'b1;
          adr_d   = dst_q;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_WR_REQ: begin
        state_d = S_WR_WAIT;
        tmo_d   = '0;
      end

      S_WR_WAIT: begin
        if (ack_i) begin
          dst_d = dst_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_ONE) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else if (fill_mode) begin
            // Fill: dat_q still holds the fill byte
            state_d = S_WR_REQ;
            stb_d   = 1'b1;
            we_d    = 1'b1;
            adr_d   = dst_q + 1'b1;
          end else begin
            state_d = S_RD_REQ;
            stb_d   = 1'b1;
            adr_d   = src_q;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops the strobe immediately
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      tmo_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign stb_o       = stb_q;
  assign we_o        = we_q;
  assign adr_o       = adr_q;
  assign dat_o       = dat_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_copy_master.sv
// tb_wb_copy_master: directed bench for wb_copy_master with a registered-ack
// RAM responder, a write scoreboard and a read-address log.
module tb_wb_copy_master;
  localparam int DW = 8;
  localparam int AW = 9;
  localparam int LW = 10;
  localparam int SB_W = AW + DW;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          start_i = 1'b0;
  logic [AW-1:0] src_i = '0;
  logic [AW-1:0] dst_i = '0;
  logic [LW-1:0] len_i = '0;
`ifdef WB_COPY_FILL_EN
  logic          fill_i = 1'b0;
  logic [DW-1:0] fill_dat_i = '0;
`endif
  logic          busy_o, done_o, err_o, stb_o, we_o;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o;
  logic          ack_i;
  logic [DW-1:0] dat_i;
  logic [2:0]    dbg_state_o;

  wb_copy_master #(
    .WB_DATA_WIDTH(DW), .WB_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TIMEOUT(15)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .src_i(src_i), .dst_i(dst_i), .len_i(len_i),
`ifdef WB_COPY_FILL_EN
    .fill_i(fill_i), .fill_dat_i(fill_dat_i),
`endif
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
    .ack_i(ack_i), .dat_i(dat_i), .dbg_state_o(dbg_state_o)
  );

  // ---------------- counters / scoreboard ----------------
  int n_checks = 0;
  int n_pass = 0;
  int n_stb = 0;
  int n_b2b = 0;
  int n_done = 0;
  int n_unexp = 0;
  logic prev_stb = 1'b0;
  logic [SB_W-1:0] exp_q[$];
  logic [AW-1:0]   rd_q[$];
  logic [DW-1:0]   mdl [0:(1<<AW)-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- responder: RAM with registered ack ----------------
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic ack_en = 1'b1;
  logic stray = 1'b0;
  logic ack_r;
  assign ack_i = ack_r | stray;

  always @(posedge clk_i) begin
    ack_r <= stb_o && ack_en;
    if (stb_o && we_o) mem[adr_o] = dat_o;
    if (stb_o && !we_o) dat_i <= mem[adr_o];
  end

  // Bus monitor, sampled on the falling edge
  always @(negedge clk_i) begin
    logic [SB_W-1:0] e;
    if (stb_o) begin
      n_stb++;
      if (prev_stb) n_b2b++;
    end
    prev_stb = stb_o;
    if (done_o) n_done++;
    if (stb_o && !we_o) rd_q.push_back(adr_o);
    if (stb_o && we_o) begin
      if (exp_q.size() == 0) n_unexp++;
      else begin
        e = exp_q.pop_front();
        check("wr_addr_data", 32'({adr_o, dat_o}), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
    logic [AW-1:0] sa, da;
    logic [DW-1:0] v;
    sa = s;
    da = d;
    for (int i = 0; i < n; i++) begin
      v = mdl[sa];
      mdl[da] = v;
      exp_q.push_back({da, v});
      sa = sa + 1'b1;
      da = da + 1'b1;
    end
  endtask

  task automatic run(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] l,
                     output int cyc, output logic b1, output logic e1);
    @(negedge clk_i);
    start_i = 1'b1; src_i = s; dst_i = d; len_i = l;
    cyc = 0; b1 = 1'b0; e1 = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      cyc++;
      if (cyc == 1) begin b1 = busy_o; e1 = err_o; end
      if (done_o) break;
    end
    check("done_seen", done_o, 1'b1);
    check("busy_low_at_done", busy_o, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc, s0, d0, wcnt, ln;
    logic b1, e1;
    logic [AW-1:0] rs, rd;
    logic [DW-1:0] v, old2, old3;

    for (int i = 0; i < (1 << AW); i++) begin
      v = DW'($urandom_range(0, 255));
      mem[i] = v;
      mdl[i] = v;
    end

    // Reset state
    #23;
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_stb", stb_o, 1'b0);
    check("rst_we", we_o, 1'b0);
    check("rst_adr", adr_o, '0);
    check("rst_dat", dat_o, '0);
    check("rst_state", dbg_state_o, 3'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Stray ack while idle has no effect
    s0 = n_stb; d0 = n_done;
    @(negedge clk_i); stray = 1'b1;
    @(negedge clk_i); stray = 1'b0;
    @(negedge clk_i);
    check("stray_busy", busy_o, 1'b0);
    check("stray_state", dbg_state_o, 3'd0);
    check("stray_no_stb", n_stb - s0, 0);
    check("stray_no_done", n_done - d0, 0);

    // Basic copy of 4 bytes
    for (int i = 0; i < 4; i++) begin
      mem[9'h010 + i] = 8'hA0 + 8'(i);
      mdl[9'h010 + i] = 8'hA0 + 8'(i);
    end
    push_copy(9'h010, 9'h100, 4);
    run(9'h010, 9'h100, 4, cyc, b1, e1);
    check("copy4_cycles", cyc, 17);
    check("copy4_busy", b1, 1'b1);
    check("copy4_err", err_o, 1'b0);
    for (int i = 0; i < 4; i++) check("copy4_ram", mem[9'h100 + i], 8'hA0 + 8'(i));
    check("copy4_sb_empty", exp_q.size(), 0);

    // Zero length
    s0 = n_stb;
    run(9'h020, 9'h030, 0, cyc, b1, e1);
    check("len0_cycles", cyc, 1);
    check("len0_busy", b1, 1'b0);
    check("len0_no_stb", n_stb - s0, 0);

    // Address wrap on the source side
    rd_q.delete();
    push_copy(9'h1FE, 9'h000, 3);
    run(9'h1FE, 9'h000, 3, cyc, b1, e1);
    check("wrap_cycles", cyc, 13);
    check("wrap_nreads", rd_q.size(), 3);
    if (rd_q.size() == 3) begin
      check("wrap_rd0", rd_q[0], 9'h1FE);
      check("wrap_rd1", rd_q[1], 9'h1FF);
      check("wrap_rd2", rd_q[2], 9'h000);
    end
    check("wrap_sb_empty", exp_q.size(), 0);

    // Random copies
    for (int t = 0; t < 3; t++) begin
      rs = AW'($urandom_range(0, 511));
      rd = AW'($urandom_range(0, 511));
      ln = $urandom_range(1, 6);
      push_copy(rs, rd, ln);
      run(rs, rd, LW'(ln), cyc, b1, e1);
      check("rand_cycles", cyc, 4 * ln + 1);
      check("rand_err", err_o, 1'b0);
      check("rand_sb_empty", exp_q.size(), 0);
    end

    // Timeout: responder never acknowledges
    ack_en = 1'b0;
    s0 = n_stb;
    run(9'h020, 9'h040, 2, cyc, b1, e1);
    check("tmo_cycles", cyc, 17);
    check("tmo_err", err_o, 1'b1);
    check("tmo_one_stb", n_stb - s0, 1);
    ack_en = 1'b1;
    @(negedge clk_i);
    check("tmo_err_sticky", err_o, 1'b1);

    // Next start clears the error
    push_copy(9'h030, 9'h031, 1);
    run(9'h030, 9'h031, 1, cyc, b1, e1);
    check("clr_err_at_start", e1, 1'b0);
    check("clr_cycles", cyc, 5);
    check("clr_sb_empty", exp_q.size(), 0);

    // Reset during WR_WAIT of byte 2
    old2 = mdl[9'h1C2];
    old3 = mdl[9'h1C3];
    push_copy(9'h180, 9'h1C0, 4);
    @(negedge clk_i);
    start_i = 1'b1; src_i = 9'h180; dst_i = 9'h1C0; len_i = 4;
    wcnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (stb_o && we_o) wcnt++;
      if (wcnt == 2) break;
    end
    check("rstmid_reached", wcnt, 2);
    @(negedge clk_i);
    check("rstmid_state", dbg_state_o, 3'd4);
    d0 = n_done;
    rst_ni = 1'b0;
    #1;
    check("rstmid_stb", stb_o, 1'b0);
    check("rstmid_busy", busy_o, 1'b0);
    repeat (3) @(negedge clk_i);
    check("rstmid_no_done", n_done - d0, 0);
    rst_ni = 1'b1;
    exp_q.delete();
    mdl[9'h1C2] = old2;
    mdl[9'h1C3] = old3;
    check("rstmid_ram0", mem[9'h1C0], mdl[9'h1C0]);
    check("rstmid_ram1", mem[9'h1C1], mdl[9'h1C1]);
    check("rstmid_ram2", mem[9'h1C2], old2);

    // Copy after reset behaves normally
    push_copy(9'h180, 9'h1C0, 4);
    run(9'h180, 9'h1C0, 4, cyc, b1, e1);
    check("post_rst_cycles", cyc, 17);
    check("post_rst_err", err_o, 1'b0);
    check("post_rst_sb_empty", exp_q.size(), 0);

`ifdef WB_COPY_FILL_EN
    // Fill mode: constant writes, no reads
    for (int i = 0; i < 8; i++) begin
      mem[9'h080 + i] = 8'hFF;
      mdl[9'h080 + i] = 8'h00;
      exp_q.push_back({9'h080 + 9'(i), 8'h00});
    end
    rd_q.delete();
    fill_i = 1'b1; fill_dat_i = 8'h00;
    run(9'h1F0, 9'h080, 8, cyc, b1, e1);
    fill_i = 1'b0;
    check("fill_cycles", cyc, 17);
    check("fill_no_reads", rd_q.size(), 0);
    for (int i = 0; i < 8; i++) check("fill_ram", mem[9'h080 + i], 8'h00);
    check("fill_sb_empty", exp_q.size(), 0);
`endif

    // Global bus properties
    repeat (2) @(negedge clk_i);
    check("no_b2b_stb", n_b2b, 0);
    check("no_unexpected_wr", n_unexp, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_copy_master.md
# wb_copy_master

Wishbone initiator that copies a block of bytes from one address range to another over a single shared bus. It is the master-side counterpart of the on-chip `wb_ram`-style responders: it issues one single-cycle strobe per access and waits for the responder's registered acknowledge. Typical use is clearing or relocating RAM regions (cartridge banks, scratch buffers) without CPU involvement.

## Interface
- WB_DATA_WIDTH, 8, bus data width
- WB_ADDR_WIDTH, 9, bus address width
- LEN_WIDTH, 10, transfer-length width; must be ≥ WB_ADDR_WIDTH+1 so a full address space can be copied
- TIMEOUT, 15, maximum cycles waited for `ack_i` after each strobe; must be ≥ 1

- clk_i  in  1  clock, all logic on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- start_i  in  1  begin a copy; sampled only in IDLE
- src_i  in  WB_ADDR_WIDTH  first source address, sampled with start
- dst_i  in  WB_ADDR_WIDTH  first destination address, sampled with start
- len_i  in  LEN_WIDTH  byte count, sampled with start
- busy_o  out  1  high from the cycle after accepted start until done
- done_o  out  1  one-cycle pulse at end of copy (success or error)
- err_o  out  1  sticky timeout flag, cleared on next accepted start
- stb_o  out  1  Wishbone strobe
- we_o  out  1  write enable
- adr_o  out  WB_ADDR_WIDTH  bus address
- dat_o  out  WB_DATA_WIDTH  write data
- ack_i  in  1  responder acknowledge
- dat_i  in  WB_DATA_WIDTH  read data

## Operation
- All outputs registered. Reset values: busy_o, done_o, err_o, stb_o, we_o = 0; adr_o, dat_o = 0; internal state IDLE, counters 0.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
- IDLE: on start_i: latch src/dst/len, clear err_o, assert busy_o. len = 0 → stay IDLE, pulse done_o next cycle, no bus activity. Otherwise → RD_REQ.
- RD_REQ: stb_o=1, we_o=0, adr_o=src pointer for exactly one cycle → RD_WAIT.
- RD_WAIT: stb_o=0; on ack_i capture dat_i into holding register, increment src pointer → WR_REQ.
- WR_REQ: stb_o=1, we_o=1, adr_o=dst pointer, dat_o=held byte for one cycle → WR_WAIT.
- WR_WAIT: stb_o=0; on ack_i increment dst pointer, decrement remaining count; remaining becomes 0 → IDLE with done_o pulse, busy_o low; else → RD_REQ.
- Pointers wrap modulo 2^WB_ADDR_WIDTH (0x1FF + 1 → 0x000 at default width).
- ack_i is ignored outside the WAIT states (stray acks have no effect).
- Timeout: counter cleared on entry to each WAIT state, increments each WAIT cycle without ack. Reaching TIMEOUT → set err_o, pulse done_o, drop busy_o, return IDLE. ack_i in the same cycle the limit is reached wins (no error).
- start_i while busy_o is high is ignored.
- rst_ni low mid-transfer: stb_o drops immediately (async), transfer discarded, no done_o.

## Timing
- Start accepted at edge k; stb_o high in cycle k+1.
- Against a responder acknowledging one cycle after strobe: 4 cycles per byte; N bytes → done_o pulses in cycle k+4N+1, busy_o falls same cycle.
- Each access keeps stb_o high for exactly one cycle; minimum one cycle of stb_o low between accesses.
- err_o rises in the same cycle as the error done_o pulse.

## Configuration
- WB_COPY_FILL_EN defined: adds inputs fill_i (1) and fill_dat_i (WB_DATA_WIDTH), sampled with start. fill_i=1 skips RD_REQ/RD_WAIT, writes fill_dat_i to every destination address; 2 cycles per byte; src_i ignored.
- Not defined: ports absent, copy-only behaviour as above.

## Test plan
- Copy src=0x010 dst=0x100 len=4 with RAM preloaded 0xA0..0xA3 → RAM[0x100..0x103]=0xA0..0xA3, done_o pulse 17 cycles after start edge, err_o=0.
- len=0 → done_o one cycle after start, stb_o never asserted.
- src=0x1FE dst=0x000 len=3 → reads 0x1FE, 0x1FF, 0x000 in order (wrap), writes 0x000..0x002.
- Responder never acks, TIMEOUT=15 → err_o=1 and done_o after 15 wait cycles following first strobe; next start clears err_o.
- Assert rst_ni low during WR_WAIT of byte 2 → stb_o, busy_o low immediately, no done_o; following start copies normally.
- WB_COPY_FILL_EN, fill_i=1, fill_dat_i=0x00, dst=0x080, len=8 → RAM[0x080..0x087]=0x00, no read strobes, done_o 17 cycles after start.
